// File: rtl/extensor_param.sv
// -----------------------------------------------------------------------------
// extensor_param
//   Immediate extender with a 2-entry in-order output buffer (head + skid).
//   The extension is computed when an input is accepted and stored, so later
//   changes on entrada/modo never alter a buffered result.
//
//   Modes (modo):
//     00 SEXT : sign-extend entrada to OUT_W bits
//     01 ZEXT : zero-extend entrada to OUT_W bits
//     10 LUI  : entrada in the top IN_W bits, lower bits zero
//     11 SHL2 : SEXT value shifted left by 2 (overflow bits dropped)
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. The input side accepts when in_valid && in_ready. The output side
//   pops when out_valid && out_ready. in_ready only looks at the local
//   occupancy, rst_n and flush, never at out_ready.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset (highest priority)
//   flush      : drops every buffered result (priority over accept/pop)
//   in_valid   : entrada/modo valid this cycle
//   in_ready   : block can accept an input this cycle
//   entrada    : IN_W-bit immediate
//   modo       : 2-bit extension mode
//   out_valid  : extendido holds a result
//   out_ready  : consumer takes extendido this cycle
//   extendido  : OUT_W-bit extended result (0 when empty)
//   count      : number of buffered results, 0..2
//
// Parameters: IN_W >= 2, OUT_W > IN_W + 2.
// -----------------------------------------------------------------------------
module extensor_param #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  entrada,
    input  logic [1:0]       modo,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] extendido,
    output logic [1:0]       count
);

    localparam int EXT_W = OUT_W - IN_W;

    logic [OUT_W-1:0] head_q, head_d;
    logic [OUT_W-1:0] skid_q, skid_d;
    logic [1:0]       count_q, count_d;

    logic [OUT_W-1:0] sext_val;
    logic [OUT_W-1:0] ext_val;
    logic             accept;
    logic             pop;

    // Extension of the value currently presented on the input
    always_comb begin
        sext_val = {{EXT_W{entrada[IN_W-1]}}, entrada};
        ext_val  = sext_val;
        case (modo)
            2'b00:   ext_val = sext_val;
            2'b01:   ext_val = {{EXT_W{1'b0}}, entrada};
            2'b10:   ext_val = {entrada, {EXT_W{1'b0}}};
            default: ext_val = sext_val << 2;
        endcase
    end

    assign in_ready  = (count_q != 2'd2) && rst_n && !flush;
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            skid_d  = '0;
            count_d = 2'd0;
        end else begin
            case ({accept, pop})
                2'b10: begin
                    // Fill the head if empty, otherwise park in the skid slot
                    if (count_q == 2'd0) begin
                        head_d  = ext_val;
                        count_d = 2'd1;
                    end else begin
                        skid_d  = ext_val;
                        count_d = 2'd2;
                    end
                end
                2'b01: begin
                    // Skid moves forward; an emptied head is cleared so the
                    // output reads 0 with nothing buffered
                    head_d  = skid_q;
                    skid_d  = '0;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Only reachable with count 1 (count 2 blocks accept):
                    // new value replaces the departing head
                    head_d = ext_val;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            skid_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end

    assign extendido = (count_q != 2'd0) ? head_q : '0;
    assign count     = count_q;

endmodule

// File: tb/tb_extensor_param.sv
// -----------------------------------------------------------------------------
// tb_extensor_param
//   Scoreboard bench for extensor_param. A monitor on the falling edge keeps
//   an expected queue of buffered results, computed with plain arithmetic
//   from the mode rules, and compares occupancy, handshake and data against
//   the DUT. A second small instance (IN_W=8, OUT_W=16) is checked directly.
// -----------------------------------------------------------------------------
module tb_extensor_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] entrada;
    logic [1:0]  modo;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] extendido;
    logic [1:0]  count;

    logic        s_flush;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_entrada;
    logic [1:0]  s_modo;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [15:0] s_extendido;
    logic [1:0]  s_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] popped_q[$];

    extensor_param dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .entrada   (entrada),
        .modo      (modo),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .extendido (extendido),
        .count     (count)
    );

    extensor_param #(.IN_W(8), .OUT_W(16)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (s_flush),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .entrada   (s_entrada),
        .modo      (s_modo),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .extendido (s_extendido),
        .count     (s_count)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference extension from the mode definitions, using integer arithmetic
    function automatic logic [31:0] ref_ext(input logic [31:0] e, input logic [1:0] m,
                                            input int in_w, input int out_w);
        longint unsigned v, sv, modv, r;
        modv = 64'd1 << out_w;
        v    = 64'(e);
        if (v >= (64'd1 << (in_w - 1)))
            sv = v + modv - (64'd1 << in_w);   // negative value wrapped into out_w bits
        else
            sv = v;
        case (m)
            2'd0:    r = sv;
            2'd1:    r = v;
            2'd2:    r = (v * (64'd1 << (out_w - in_w))) % modv;
            default: r = (sv * 64'd4) % modv;
        endcase
        return r[31:0];
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int sz;
    always @(negedge clk) begin
        sz = exp_q.size();
        if (!rst_n) begin
            check("in_ready_in_reset", {31'd0, in_ready}, 32'd0);
            exp_q.delete();
        end else begin
            check("count", {30'd0, count}, sz);
            check("out_valid", {31'd0, out_valid}, (sz != 0) ? 32'd1 : 32'd0);
            check("in_ready", {31'd0, in_ready}, (sz < 2 && !flush) ? 32'd1 : 32'd0);
            if (sz == 0) check("extendido_empty", extendido, 32'd0);
            else         check("extendido", extendido, exp_q[0]);
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_ready && sz > 0) begin
                    popped_q.push_back(extendido);
                    void'(exp_q.pop_front());
                end
                if (in_valid && sz < 2)
                    exp_q.push_back(ref_ext({16'd0, entrada}, modo, 16, 32));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; holds the input until accepted, returns at posedge+1
    task automatic send(input logic [15:0] e, input logic [1:0] m);
        int waited = 0;
        in_valid = 1'b1;
        entrada  = e;
        modo     = m;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_popped(input string name, input int idx, input logic [31:0] exp);
        if (popped_q.size() > idx) check(name, popped_q[idx], exp);
        else                       check({name, "_missing"}, 32'hDEAD_BEEF, exp);
    endtask

    task automatic small_check(input logic [1:0] m, input logic [15:0] exp);
        @(posedge clk); #1;
        s_in_valid = 1'b1;
        s_entrada  = 8'h80;
        s_modo     = m;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        @(negedge clk);
        check("small_out_valid", {31'd0, s_out_valid}, 32'd1);
        check("small_extendido", {16'd0, s_extendido}, {16'd0, exp});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; entrada = '0; modo = '0; out_ready = 1'b0;
        s_flush = 1'b0; s_in_valid = 1'b0; s_entrada = '0; s_modo = '0; s_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(2);

        // Back-to-back, all four modes, consumer always ready
        out_ready = 1'b1;
        popped_q.delete();
        send(16'h8001, 2'd0);
        send(16'h8001, 2'd1);
        send(16'h8001, 2'd2);
        send(16'h8001, 2'd3);
        idle_cycles(3);
        check_popped("sext_8001", 0, 32'hFFFF8001);
        check_popped("zext_8001", 1, 32'h00008001);
        check_popped("lui_8001",  2, 32'h80010000);
        check_popped("shl2_8001", 3, 32'hFFFE0004);

        // Backpressure: third input held until the consumer drains
        out_ready = 1'b0;
        popped_q.delete();
        fork
            begin
                send(16'h0001, 2'd0);
                send(16'h0002, 2'd0);
                send(16'h0003, 2'd0);
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle_cycles(4);
        check_popped("bp_first",  0, 32'h00000001);
        check_popped("bp_second", 1, 32'h00000002);
        check_popped("bp_third",  2, 32'h00000003);

        // Accept and pop in the same cycle at count 1
        out_ready = 1'b0;
        send(16'h1234, 2'd1);
        out_ready = 1'b1;
        send(16'hABCD, 2'd2);
        idle_cycles(3);

        // Flush at count 2 beats a simultaneous input
        out_ready = 1'b0;
        send(16'h0011, 2'd0);
        send(16'h0022, 2'd0);
        flush = 1'b1; in_valid = 1'b1; entrada = 16'h0033;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_count", {30'd0, count}, 32'd0);
        check("flush_extendido", extendido, 32'd0);
        idle_cycles(1);

        // Reset mid-operation at count 2
        send(16'h0044, 2'd0);
        send(16'h0055, 2'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        popped_q.delete();
        send(16'h7FFF, 2'd1);
        idle_cycles(3);
        check_popped("after_reset_zext", 0, 32'h00007FFF);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            entrada   = 16'($urandom);
            modo      = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst_n     = ($urandom_range(0, 99) != 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        idle_cycles(4);

        // Narrow instance
        small_check(2'd0, 16'hFF80);
        small_check(2'd2, 16'h8000);
        small_check(2'd3, 16'hFE00);
        idle_cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/extensor_param.md
EXTENSOR_PARAM -- requirements
Module: extensor_param

Interface
REQ-001 Parameter IN_W, default 16, immediate input width in bits; SHALL be >= 2.
REQ-002 Parameter OUT_W, default 32, extended output width in bits; SHALL be > IN_W + 2.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port flush  input  1  discards all buffered results.
REQ-006 Port in_valid  input  1  entrada/modo valid this cycle.
REQ-007 Port in_ready  output  1  block can accept an input this cycle.
REQ-008 Port entrada  input  IN_W  immediate to extend.
REQ-009 Port modo  input  2  extension mode: 00 SEXT, 01 ZEXT, 10 LUI, 11 SHL2.
REQ-010 Port out_valid  output  1  extendido holds a result.
REQ-011 Port out_ready  input  1  consumer takes extendido this cycle.
REQ-012 Port extendido  output  OUT_W  extended result.
REQ-013 Port count  output  2  number of buffered results, 0..2.

Function
REQ-014 SEXT SHALL produce entrada replicated-sign-extended to OUT_W bits.
REQ-015 ZEXT SHALL produce entrada zero-extended to OUT_W bits.
REQ-016 LUI SHALL place entrada in bits [OUT_W-1:OUT_W-IN_W], all lower bits 0.
REQ-017 SHL2 SHALL produce the SEXT value shifted left by 2, bits shifted past OUT_W-1 dropped, bits [1:0] = 0.
REQ-018 Extension SHALL be computed at acceptance and stored; later changes of entrada/modo SHALL NOT affect stored results.
REQ-019 Accept SHALL occur when in_valid and in_ready are both 1 at a rising edge.
REQ-020 Pop SHALL occur when out_valid and out_ready are both 1 at a rising edge.
REQ-021 Storage SHALL be a 2-entry in-order buffer: head entry (drives extendido) and skid entry.
REQ-022 Latency: an input accepted at edge N SHALL appear on extendido with out_valid = 1 after edge N when the buffer was empty or the head popped at N with no skid entry.
REQ-023 Throughput SHALL be one result per cycle while out_ready = 1.
REQ-024 in_ready SHALL equal (count < 2) and rst_n and not flush; it SHALL NOT depend combinationally on out_ready.
REQ-025 Simultaneous accept and pop SHALL leave count unchanged and preserve order.
REQ-026 Accept with head full and not popping SHALL write the skid entry; a later pop SHALL move skid to head.
REQ-027 With count = 2, in_valid SHALL be ignored (in_ready = 0) and no data lost.
REQ-028 While out_valid = 1 and out_ready = 0, extendido SHALL remain stable.
REQ-029 out_valid SHALL equal (count != 0).
REQ-030 flush = 1 at an edge SHALL set count to 0; flush SHALL take priority over a simultaneous accept or pop.
REQ-031 extendido SHALL read 0 whenever count = 0.

Reset
REQ-032 rst_n = 0 at an edge SHALL set count = 0, out_valid = 0, extendido = 0, both entries cleared.
REQ-033 While rst_n = 0, in_ready SHALL be 0 and no accept SHALL occur.
REQ-034 Reset mid-operation SHALL discard all buffered results; the first input after release SHALL be accepted as if from empty.
REQ-035 Reset SHALL take priority over flush, accept and pop.

Verification
REQ-036 Defaults, out_ready = 1: accept 16'h8001 in SEXT, ZEXT, LUI, SHL2 on consecutive cycles -> 32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004, one per cycle, each one cycle after acceptance.
REQ-037 out_ready = 0, stream 16'h0001, 16'h0002, 16'h0003 SEXT -> count 1 then 2, in_ready 0 at count 2, third input held; raising out_ready -> 32'h00000001, 32'h00000002, 32'h00000003 in order.
REQ-038 count = 1, in_valid = 1 with out_ready = 1 same cycle -> count stays 1, extendido shows new value next cycle.
REQ-039 count = 2, flush = 1 with in_valid = 1 -> count 0, out_valid 0, extendido 0, input not accepted.
REQ-040 count = 2, rst_n = 0 for one cycle -> count 0, in_ready 0 during reset, 1 after; next 16'h7FFF ZEXT -> 32'h00007FFF.
REQ-041 IN_W = 8, OUT_W = 16: 8'h80 SEXT -> 16'hFF80, LUI -> 16'h8000, SHL2 -> 16'hFE00.
